// File: rtl/smult_seq_if.sv
// ---------------------------------------------------------------------------
// smult_seq_if
//
// Purpose:
//   Bundles every non-clock signal of the sequenced scalar-by-vector FP16
//   multiply controller into one interface. It covers the request/result
//   handshake towards the vector register file and writeback mux. It also
//   carries the operand/product bus towards the single shared lane
//   multiplier (VMULT).
//
// Modports:
//   slave  - seen by smult_seq itself (takes requests, drives the multiplier).
//   master - seen by the surrounding environment. That is the requester plus
//            the external multiplier. The environment drives start, scalar,
//            vecin, mul_p and mul_ov, and observes everything else.
//
// Signals:
//   start   request pulse, only looked at while the controller is idle
//   scalar  EW-bit scalar operand
//   vecin   LANES*EW-bit vector operand, lane i = vecin[i*EW +: EW]
//   product LANES*EW-bit assembled result vector (registered)
//   V       sticky OR of per-lane multiplier overflow
//   busy    high while an operation is running or completing
//   done    one-cycle completion pulse
//   mul_a   multiplier operand A (the scalar)
//   mul_b   multiplier operand B (the current vector element)
//   mul_p   multiplier product, combinational from mul_a/mul_b
//   mul_ov  multiplier overflow flag for the current lane
//
// LANES and EW must match the parameters of the smult_seq instance that
// the interface is connected to.
// ---------------------------------------------------------------------------
interface smult_seq_if #(
    parameter int LANES = 16,
    parameter int EW    = 16
) ();

    logic                  start;
    logic [EW-1:0]         scalar;
    logic [LANES*EW-1:0]   vecin;
    logic [LANES*EW-1:0]   product;
    logic                  V;
    logic                  busy;
    logic                  done;
    logic [EW-1:0]         mul_a;
    logic [EW-1:0]         mul_b;
    logic [EW-1:0]         mul_p;
    logic                  mul_ov;

    modport master (
        output start,
        output scalar,
        output vecin,
        output mul_p,
        output mul_ov,
        input  product,
        input  V,
        input  busy,
        input  done,
        input  mul_a,
        input  mul_b
    );

    modport slave (
        input  start,
        input  scalar,
        input  vecin,
        input  mul_p,
        input  mul_ov,
        output product,
        output V,
        output busy,
        output done,
        output mul_a,
        output mul_b
    );

endinterface

// File: rtl/smult_seq.sv
// ---------------------------------------------------------------------------
// smult_seq
//
// Purpose:
//   Sequenced scalar-by-vector half-precision multiply controller. One
//   external single-lane FP16 multiplier is time-multiplexed across all
//   vector elements, instead of a LANES-wide parallel array. On an accepted
//   start the scalar and vector are latched. Elements are then walked from
//   lane 0 upward, one per clock. Each multiplier result is stored verbatim
//   into its lane of the product vector, and the per-lane overflow flags are
//   ORed into a sticky V. The block then pulses done for one cycle. No
//   arithmetic happens here.
//
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous, active-high reset; discards any partial result
//   bus  - smult_seq_if.slave: start/scalar/vecin request, product/V/busy/
//          done result, and the mul_a/mul_b/mul_p/mul_ov multiplier bus
//
// Parameters:
//   LANES - number of EW-bit elements per vector
//   EW    - element width (FP16 = 16)
//   IW    - lane index width, 2**IW must be >= LANES
//
// Optional feature (compile-time macro SMULT_SEQ_OVF_STOP_EN):
//   When defined, the first lane whose multiplier reports overflow still has
//   its product stored and sets V. The sequence then ends early and moves
//   straight to DONE, so the remaining lanes stay zero. When undefined,
//   every lane is always processed and the latency is fixed.
//
// Timing (default build), with the start accepted at edge E0:
//   lanes 0..LANES-1 are written at edges E1..E_LANES, done is high between
//   E_LANES and E_LANES+1, and the next start can be accepted at E_LANES+2.
// ---------------------------------------------------------------------------
module smult_seq #(
    parameter int LANES = 16,
    parameter int EW    = 16,
    parameter int IW    = 4
) (
    input  logic        clk,
    input  logic        rst,
    smult_seq_if.slave  bus
);

    localparam int VW = LANES * EW;
    localparam logic [IW-1:0] LAST_IDX = IW'(LANES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t            state_q,   state_d;
    logic [IW-1:0]     idx_q,     idx_d;
    logic [EW-1:0]     scalar_q,  scalar_d;
    logic [VW-1:0]     vec_q,     vec_d;
    logic [VW-1:0]     product_q, product_d;
    logic              ovf_q,     ovf_d;
    logic              busy_q,    busy_d;
    logic              done_q,    done_d;
    logic [EW-1:0]     mul_a_q,   mul_a_d;
    logic [EW-1:0]     mul_b_q,   mul_b_d;

    logic              last_lane;
    logic              stop_now;
    int                cur_base;
    int                next_base;

    // Next-state and datapath logic. The multiplier operands are
    // registered. They are loaded one cycle ahead with the element that the
    // next RUN cycle will multiply. In RUN, mul_b therefore always shows
    // vec_q[idx], and mul_p can be captured directly at the following edge.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        scalar_d  = scalar_q;
        vec_d     = vec_q;
        product_d = product_q;
        ovf_d     = ovf_q;
        busy_d    = busy_q;
        done_d    = done_q;
        mul_a_d   = mul_a_q;
        mul_b_d   = mul_b_q;

        cur_base  = int'(idx_q) * EW;
        next_base = (int'(idx_q) + 1) * EW;
        last_lane = (idx_q == LAST_IDX);

`ifdef SMULT_SEQ_OVF_STOP_EN
        // Early termination: the overflowing lane is still stored below,
        // and then the sequence finishes instead of advancing.
        stop_now  = last_lane | bus.mul_ov;
`else
        stop_now  = last_lane;
`endif

        case (state_q)
            S_IDLE: begin
                mul_a_d = '0;
                mul_b_d = '0;
                done_d  = 1'b0;
                busy_d  = 1'b0;
                if (bus.start) begin
                    // Operands are latched here, so the caller may change
                    // them freely from the next cycle on.
                    scalar_d  = bus.scalar;
                    vec_d     = bus.vecin;
                    product_d = '0;
                    ovf_d     = 1'b0;
                    idx_d     = '0;
                    busy_d    = 1'b1;
                    mul_a_d   = bus.scalar;
                    mul_b_d   = bus.vecin[0 +: EW];
                    state_d   = S_RUN;
                end
            end

            S_RUN: begin
                product_d[cur_base +: EW] = bus.mul_p;
                ovf_d                     = ovf_q | bus.mul_ov;
                if (stop_now) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    mul_a_d = '0;
                    mul_b_d = '0;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    mul_b_d = vec_q[next_base +: EW];
                end
            end

            S_DONE: begin
                // A start arriving here is dropped, not queued.
                state_d = S_IDLE;
                done_d  = 1'b0;
                busy_d  = 1'b0;
                mul_a_d = '0;
                mul_b_d = '0;
            end

            default: begin
                state_d = S_IDLE;
                done_d  = 1'b0;
                busy_d  = 1'b0;
                mul_a_d = '0;
                mul_b_d = '0;
            end
        endcase
    end

    // State and output registers. Reset clears everything, including the
    // operand latches and any partially assembled product.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            scalar_q  <= '0;
            vec_q     <= '0;
            product_q <= '0;
            ovf_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            mul_a_q   <= '0;
            mul_b_q   <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            scalar_q  <= scalar_d;
            vec_q     <= vec_d;
            product_q <= product_d;
            ovf_q     <= ovf_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            mul_a_q   <= mul_a_d;
            mul_b_q   <= mul_b_d;
        end
    end

    assign bus.product = product_q;
    assign bus.V       = ovf_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.mul_a   = mul_a_q;
    assign bus.mul_b   = mul_b_q;

endmodule

// File: tb/tb_smult_seq.sv
// ---------------------------------------------------------------------------
// tb_smult_seq
//
// Self-checking bench for smult_seq. A behavioural FP16 multiplier answers on
// the mul bus. Each accepted request pushes its expected product vector, V
// and done latency onto a scoreboard. That entry is popped and compared when
// done is observed. Works with and without SMULT_SEQ_OVF_STOP_EN defined.
// ---------------------------------------------------------------------------
module tb_smult_seq;

   localparam int LANES = 16;
   localparam int EW    = 16;
   localparam int IW    = 4;
   localparam int VW    = LANES * EW;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic force_ov = 1'b0;
   logic [16:0] beh;

   typedef struct {
      logic [VW-1:0] product;
      logic          v;
      int            latency;
   } exp_t;

   exp_t sb[$];
   int   checks_total  = 0;
   int   checks_passed = 0;
   logic [EW-1:0] mulb_seen [LANES];
   logic [EW-1:0] mula_seen [LANES];

   smult_seq_if #(.LANES(LANES), .EW(EW)) bus_if ();

   smult_seq #(.LANES(LANES), .EW(EW), .IW(IW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus_if)
   );

   // Free-running clock, 10 time units per period
   always #5 clk = ~clk;

   // Behavioural FP16 multiply, round to nearest even. Returns {ov, product}.
   // An Inf/NaN operand or an exponent overflow yields signed Inf with ov=1.
   function automatic logic [16:0] fp16_mul(input logic [15:0] a, input logic [15:0] b);
      logic        sgn;
      int          ea, eb, m, s, e;
      logic        sub;
      logic [63:0] siga, sigb, prod, q, rem, half;
      sgn = a[15] ^ b[15];
      ea  = int'(a[14:10]);
      eb  = int'(b[14:10]);
      if (ea == 31 || eb == 31) return {1'b1, sgn, 15'h7c00};
      if (a[14:0] == 15'h0 || b[14:0] == 15'h0) return {1'b0, sgn, 15'h0};
      siga = 64'({(ea != 0), a[9:0]});
      sigb = 64'({(eb != 0), b[9:0]});
      if (ea == 0) ea = 1;
      if (eb == 0) eb = 1;
      prod = siga * sigb;
      m = 0;
      for (int i = 0; i < 24; i++) if (prod[i]) m = i;
      sub = ((m - 10) < (26 - ea - eb));
      s   = sub ? (26 - ea - eb) : (m - 10);
      if (s > 0) begin
         q    = prod >> s;
         rem  = prod & ((64'd1 << s) - 64'd1);
         half = 64'd1 << (s - 1);
         if (rem > half || (rem == half && q[0])) q = q + 64'd1;
      end else begin
         q = prod << (-s);
      end
      if (sub) return {1'b0, sgn, q[14:0]};
      e = m + ea + eb - 35;
      if (q == 64'd2048) begin
         q = 64'd1024;
         e = e + 1;
      end
      if (e >= 31) return {1'b1, sgn, 15'h7c00};
      return {1'b0, sgn, 5'(e), q[9:0]};
   endfunction

   // Reference result for one request; ov_lane < 0 means no forced overflow
   function automatic exp_t model(input logic [EW-1:0] sc, input logic [VW-1:0] v, input int ov_lane);
      exp_t        r;
      logic [16:0] x;
      logic        ov;
      r.product = '0;
      r.v       = 1'b0;
      r.latency = LANES;
      for (int i = 0; i < LANES; i++) begin
         x  = fp16_mul(sc, v[i*EW +: EW]);
         ov = x[16] | (i == ov_lane);
         r.product[i*EW +: EW] = x[15:0];
         r.v = r.v | ov;
`ifdef SMULT_SEQ_OVF_STOP_EN
         if (ov) begin
            r.latency = i + 1;
            break;
         end
`endif
      end
      return r;
   endfunction

   // The external multiplier answers combinationally on the mul bus
   always_comb beh = fp16_mul(bus_if.mul_a, bus_if.mul_b);
   assign bus_if.mul_p  = beh[15:0];
   assign bus_if.mul_ov = beh[16] | force_ov;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Drives a start pulse accepted at the next edge and records the expectation
   task automatic applyStimulus(input logic [EW-1:0] sc, input logic [VW-1:0] v, input int ov_lane);
      bus_if.scalar = sc;
      bus_if.vecin  = v;
      bus_if.start  = 1'b1;
      sb.push_back(model(sc, v, ov_lane));
      step();
      bus_if.start  = 1'b0;
   endtask

   // Waits (bounded) for done; edges counted from the edge preceding the call
   task automatic wait_done(output int edges, output bit found, output int busy_cycles);
      edges = 0;
      found = 1'b0;
      busy_cycles = 0;
      for (int i = 0; i < 64; i++) begin
         if (bus_if.busy) busy_cycles++;
         if (i < LANES && !bus_if.done) begin
            mulb_seen[i] = bus_if.mul_b;
            mula_seen[i] = bus_if.mul_a;
         end
         if (bus_if.done) begin
            edges = i;
            found = 1'b1;
            break;
         end
         step();
      end
   endtask

   task automatic test_reset();
      logic [VW-1:0] v;
      repeat (2) @(posedge clk);
      #1;
      checks_total++;
      if (bus_if.busy !== 1'b0 || bus_if.done !== 1'b0) $display("[TB] FAIL reset_idle_flags: got busy=%b done=%b, expected 0 0", bus_if.busy, bus_if.done);
      else checks_passed++;
      rst = 1'b0;
      step();
      v = {LANES{16'h3c00}};
      applyStimulus(16'h3c00, v, -1);
      repeat (3) step();
      checks_total++;
      if (bus_if.product[EW-1:0] !== 16'h3c00) $display("[TB] FAIL reset_pre_lane0: got %h, expected 3c00", bus_if.product[EW-1:0]);
      else checks_passed++;
      #3 rst = 1'b1;
      #1;
      checks_total++;
      if (bus_if.product !== '0) $display("[TB] FAIL reset_product: got %h, expected 0", bus_if.product);
      else checks_passed++;
      checks_total++;
      if (bus_if.V !== 1'b0 || bus_if.busy !== 1'b0 || bus_if.done !== 1'b0) $display("[TB] FAIL reset_flags: got V=%b busy=%b done=%b, expected 0 0 0", bus_if.V, bus_if.busy, bus_if.done);
      else checks_passed++;
      checks_total++;
      if (bus_if.mul_a !== 16'h0 || bus_if.mul_b !== 16'h0) $display("[TB] FAIL reset_mul_ops: got a=%h b=%h, expected 0000 0000", bus_if.mul_a, bus_if.mul_b);
      else checks_passed++;
      void'(sb.pop_back());
      @(posedge clk);
      #1;
      rst = 1'b0;
      step();
   endtask

   task automatic test_basic();
      logic [VW-1:0] v;
      exp_t e;
      int edges, busy_cycles;
      bit found;
      v = {LANES{16'h3c00}};
      applyStimulus(16'h3c00, v, -1);
      wait_done(edges, found, busy_cycles);
      e = sb.pop_front();
      checks_total++;
      if (!found || edges != e.latency) $display("[TB] FAIL basic_latency: got found=%0b edges=%0d, expected edges=%0d", found, edges, e.latency);
      else checks_passed++;
      checks_total++;
      if (busy_cycles != e.latency + 1) $display("[TB] FAIL basic_busy_len: got %0d, expected %0d", busy_cycles, e.latency + 1);
      else checks_passed++;
      checks_total++;
      if (bus_if.product !== e.product || bus_if.product !== {LANES{16'h3c00}}) $display("[TB] FAIL basic_product: got %h, expected %h", bus_if.product, e.product);
      else checks_passed++;
      checks_total++;
      if (bus_if.V !== 1'b0) $display("[TB] FAIL basic_v: got %b, expected 0", bus_if.V);
      else checks_passed++;
      step();
      checks_total++;
      if (bus_if.done !== 1'b0 || bus_if.busy !== 1'b0) $display("[TB] FAIL basic_done_pulse: got done=%b busy=%b, expected 0 0", bus_if.done, bus_if.busy);
      else checks_passed++;
      repeat (3) step();
      checks_total++;
      if (bus_if.product !== e.product || bus_if.V !== e.v) $display("[TB] FAIL basic_idle_hold: got %h V=%b, expected %h V=%b", bus_if.product, bus_if.V, e.product, e.v);
      else checks_passed++;
   endtask

   task automatic test_sign_order();
      logic [VW-1:0] v;
      exp_t e;
      int edges, busy_cycles, bad;
      bit found;
      for (int i = 0; i < LANES; i++) v[i*EW +: EW] = (i % 2 == 0) ? 16'h3c00 : 16'h0000;
      applyStimulus(16'hbc00, v, -1);
      wait_done(edges, found, busy_cycles);
      e = sb.pop_front();
      checks_total++;
      if (!found || edges != e.latency) $display("[TB] FAIL sign_latency: got found=%0b edges=%0d, expected edges=%0d", found, edges, e.latency);
      else checks_passed++;
      checks_total++;
      if (bus_if.product !== e.product) $display("[TB] FAIL sign_product: got %h, expected %h", bus_if.product, e.product);
      else checks_passed++;
      checks_total++;
      if (bus_if.product[EW-1:0] !== 16'hbc00 || bus_if.product[2*EW-1:EW] !== 16'h8000) $display("[TB] FAIL sign_lane01: got %h %h, expected bc00 8000", bus_if.product[EW-1:0], bus_if.product[2*EW-1:EW]);
      else checks_passed++;
      bad = -1;
      for (int i = LANES - 1; i >= 0; i--) if (mulb_seen[i] !== v[i*EW +: EW] || mula_seen[i] !== 16'hbc00) bad = i;
      checks_total++;
      if (bad >= 0) $display("[TB] FAIL sign_mul_order: lane %0d got a=%h b=%h, expected a=bc00 b=%h", bad, mula_seen[bad], mulb_seen[bad], v[bad*EW +: EW]);
      else checks_passed++;
      step();
   endtask

   task automatic test_overflow();
      logic [VW-1:0] v;
      exp_t e;
      int edges, busy_cycles;
      bit found;
      v = {LANES{16'h7cde}};
      applyStimulus(16'h7ccc, v, -1);
      wait_done(edges, found, busy_cycles);
      e = sb.pop_front();
      checks_total++;
      if (!found || edges != e.latency) $display("[TB] FAIL ovf_all_latency: got found=%0b edges=%0d, expected edges=%0d", found, edges, e.latency);
      else checks_passed++;
      checks_total++;
      if (bus_if.product !== e.product || bus_if.product[EW-1:0] !== 16'h7c00) $display("[TB] FAIL ovf_all_product: got %h, expected %h", bus_if.product, e.product);
      else checks_passed++;
      checks_total++;
      if (bus_if.V !== 1'b1) $display("[TB] FAIL ovf_all_v: got %b, expected 1", bus_if.V);
      else checks_passed++;
      step();
      // Force overflow on lane 5 only
      v = {LANES{16'h3c00}};
      applyStimulus(16'h3c00, v, 5);
      repeat (5) step();
      checks_total++;
      if (bus_if.V !== 1'b0) $display("[TB] FAIL ovf_lane_before: got %b, expected 0", bus_if.V);
      else checks_passed++;
      force_ov = 1'b1;
      step();
      force_ov = 1'b0;
      checks_total++;
      if (bus_if.V !== 1'b1) $display("[TB] FAIL ovf_lane_set: got %b, expected 1", bus_if.V);
      else checks_passed++;
      wait_done(edges, found, busy_cycles);
      e = sb.pop_front();
      checks_total++;
      if (!found || edges + 6 != e.latency) $display("[TB] FAIL ovf_lane_latency: got found=%0b edges=%0d, expected edges=%0d", found, edges + 6, e.latency);
      else checks_passed++;
      checks_total++;
      if (bus_if.product !== e.product || bus_if.V !== 1'b1) $display("[TB] FAIL ovf_lane_result: got %h V=%b, expected %h V=1", bus_if.product, bus_if.V, e.product);
      else checks_passed++;
      step();
   endtask

   task automatic test_busy_ignore();
      logic [VW-1:0] v;
      exp_t e;
      int edges, busy_cycles;
      bit found;
      for (int i = 0; i < LANES; i++) v[i*EW +: EW] = 16'h3c00 + 16'(i);
      applyStimulus(16'h4000, v, -1);
      step();
      step();
      bus_if.vecin  = {LANES{16'h7bff}};
      bus_if.scalar = 16'h5555;
      bus_if.start  = 1'b1;
      step();
      bus_if.start  = 1'b0;
      wait_done(edges, found, busy_cycles);
      e = sb.pop_front();
      checks_total++;
      if (!found || edges + 3 != e.latency) $display("[TB] FAIL busy_latency: got found=%0b edges=%0d, expected edges=%0d", found, edges + 3, e.latency);
      else checks_passed++;
      checks_total++;
      if (bus_if.product !== e.product || bus_if.V !== e.v) $display("[TB] FAIL busy_isolation: got %h V=%b, expected %h V=%b", bus_if.product, bus_if.V, e.product, e.v);
      else checks_passed++;
      bus_if.scalar = 16'h3c00;
      bus_if.vecin  = {LANES{16'h3c00}};
      bus_if.start  = 1'b1;
      step();
      bus_if.start  = 1'b0;
      checks_total++;
      if (bus_if.busy !== 1'b0 || bus_if.done !== 1'b0 || bus_if.product !== e.product) $display("[TB] FAIL busy_done_ignore: got busy=%b done=%b product=%h, expected 0 0 %h", bus_if.busy, bus_if.done, bus_if.product, e.product);
      else checks_passed++;
      step();
      checks_total++;
      if (bus_if.busy !== 1'b0) $display("[TB] FAIL busy_not_queued: got busy=%b, expected 0", bus_if.busy);
      else checks_passed++;
      for (int i = 0; i < LANES; i++) v[i*EW +: EW] = 16'hc000 - 16'(i);
      applyStimulus(16'h3800, v, -1);
      wait_done(edges, found, busy_cycles);
      e = sb.pop_front();
      checks_total++;
      if (!found || edges != e.latency || bus_if.product !== e.product) $display("[TB] FAIL busy_next_accept: got found=%0b edges=%0d product=%h, expected edges=%0d product=%h", found, edges, bus_if.product, e.latency, e.product);
      else checks_passed++;
      step();
   endtask

   task automatic test_reset_mid_run();
      logic [VW-1:0] v;
      exp_t e;
      int edges, busy_cycles, done_count;
      bit found;
      v = {LANES{16'h3c00}};
      applyStimulus(16'h3c00, v, -1);
      repeat (7) step();
      #3 rst = 1'b1;
      #1;
      checks_total++;
      if (bus_if.product !== '0 || bus_if.V !== 1'b0 || bus_if.busy !== 1'b0 || bus_if.done !== 1'b0) $display("[TB] FAIL midrun_reset: got product=%h V=%b busy=%b done=%b, expected all 0", bus_if.product, bus_if.V, bus_if.busy, bus_if.done);
      else checks_passed++;
      void'(sb.pop_back());
      @(posedge clk);
      #1;
      rst = 1'b0;
      done_count = 0;
      for (int i = 0; i < 20; i++) begin
         if (bus_if.done) done_count++;
         step();
      end
      checks_total++;
      if (done_count != 0 || bus_if.busy !== 1'b0) $display("[TB] FAIL midrun_no_done: got done pulses=%0d busy=%b, expected 0 0", done_count, bus_if.busy);
      else checks_passed++;
      v = {LANES{16'h0201}};
      applyStimulus(16'h3c80, v, -1);
      wait_done(edges, found, busy_cycles);
      e = sb.pop_front();
      checks_total++;
      if (!found || edges != e.latency) $display("[TB] FAIL midrun_fresh_latency: got found=%0b edges=%0d, expected edges=%0d", found, edges, e.latency);
      else checks_passed++;
      checks_total++;
      if (bus_if.product !== e.product || bus_if.product !== {LANES{16'h0241}}) $display("[TB] FAIL midrun_fresh_product: got %h, expected %h", bus_if.product, e.product);
      else checks_passed++;
      checks_total++;
      if (bus_if.V !== 1'b0) $display("[TB] FAIL midrun_fresh_v: got %b, expected 0", bus_if.V);
      else checks_passed++;
      step();
   endtask

   // Global time guard so a stuck run still ends with a report
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   // Main sequence of scenarios
   initial begin
      bus_if.start  = 1'b0;
      bus_if.scalar = '0;
      bus_if.vecin  = '0;
      test_reset();
      test_basic();
      test_sign_order();
      test_overflow();
      test_busy_ignore();
      test_reset_mid_run();
      $display("%0d/%0d checks passed", checks_passed, checks_total);
      $finish;
   end

endmodule
